// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Byte-serial data-memory responder for the processor load/store port.
// Takes one load or store request at a time over a valid/ready handshake.
// It services the request against an internal byte-wide RAM, one byte per
// cycle. Loads return the assembled 32-bit result, either sign-extended or
// zero-extended, together with a one-cycle response pulse.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   When defined, a misaligned request is flagged at accept and answered
//   with rsp_err instead of being performed:
//     - a half access with addr[0] set, or
//     - a word access with addr[1:0] not equal to 00.
//   When undefined, misaligned requests are performed byte by byte and
//   rsp_err is tied to 0.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   req_valid  : request present
//   req_ready  : responder idle and able to accept a request
//   req_we     : 1 = store, 0 = load
//   req_whb    : access size (00 byte, 01 half, 10/11 word)
//   req_signed : loads only, 1 = sign-extend, 0 = zero-extend
//   req_addr   : byte address
//   req_wdata  : store data, little-endian, low bytes used
//   rsp_valid  : one-cycle response pulse
//   rsp_rdata  : load result (0 for stores and errors)
//   rsp_err    : misaligned-access flag (MISALIGN_TRAP_EN only)
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_whb,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;

  // Request fields captured at accept
  logic              we_q;
  logic              signed_q;
  logic [1:0]        whb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  // Byte index of the current access and index of the final byte (N-1)
  logic [1:0]        byte_idx;
  logic [1:0]        last_idx;

  // Load assembly register, filled one byte lane per ACCESS cycle
  logic [31:0]       asm_q;

  // Byte-wide RAM; contents are deliberately not reset
  logic [7:0]        mem [0:(2**ADDR_W)-1];

  logic              accept;
  logic [1:0]        req_last_idx;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        rd_byte;
  logic [7:0]        wr_byte;
  logic [31:0]       asm_next;
  logic [31:0]       load_result;
  logic              last_byte;

  assign accept = req_valid & req_ready;

  // Final byte index for the requested size; 11 is treated as a word
  always_comb begin
    case (req_whb)
      2'b00:   req_last_idx = 2'd0;
      2'b01:   req_last_idx = 2'd1;
      default: req_last_idx = 2'd3;
    endcase
  end

  // The adder width is ADDR_W, so an access that runs past the top of the
  // RAM wraps around to byte 0 without any extra logic
  assign cur_addr  = addr_q + ADDR_W'(byte_idx);
  assign rd_byte   = mem[cur_addr];
  assign last_byte = (byte_idx == last_idx);

  // Select the store byte for the current lane
  always_comb begin
    case (byte_idx)
      2'd0:    wr_byte = wdata_q[7:0];
      2'd1:    wr_byte = wdata_q[15:8];
      2'd2:    wr_byte = wdata_q[23:16];
      default: wr_byte = wdata_q[31:24];
    endcase
  end

  // Merge the byte being read this cycle into its lane. The final
  // response is formed from this merged value, so the last byte does not
  // need an extra cycle to land in asm_q first.
  always_comb begin
    asm_next = asm_q;
    case (byte_idx)
      2'd0:    asm_next[7:0]   = rd_byte;
      2'd1:    asm_next[15:8]  = rd_byte;
      2'd2:    asm_next[23:16] = rd_byte;
      default: asm_next[31:24] = rd_byte;
    endcase
  end

  // Extend the load to 32 bits. Lanes above the access size may hold
  // stale bytes, and they are overwritten here by the extension.
  always_comb begin
    case (whb_q)
      2'b00:   load_result = {{24{signed_q & asm_next[7]}},  asm_next[7:0]};
      2'b01:   load_result = {{16{signed_q & asm_next[15]}}, asm_next[15:0]};
      default: load_result = asm_next;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic req_misaligned;
  logic err_q;

  // Half accesses need an even address; word accesses need 4-byte alignment
  assign req_misaligned = ((req_whb == 2'b01) & req_addr[0]) |
                          (req_whb[1] & (req_addr[1:0] != 2'b00));
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Main control FSM. All outputs are registered. req_ready is cleared by
  // reset and is raised again by the first IDLE clock edge, so the
  // responder does not accept a request while reset is still being sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      we_q      <= 1'b0;
      signed_q  <= 1'b0;
      whb_q     <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      byte_idx  <= 2'd0;
      last_idx  <= 2'd0;
      asm_q     <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
`ifdef MISALIGN_TRAP_EN
          err_q     <= 1'b0;
`endif
          if (accept) begin
            we_q      <= req_we;
            signed_q  <= req_signed;
            whb_q     <= req_whb;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            byte_idx  <= 2'd0;
            last_idx  <= req_last_idx;
            asm_q     <= 32'd0;
            req_ready <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            if (req_misaligned) begin
              // Trap without touching the RAM; respond in the next cycle
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= 32'd0;
              err_q     <= 1'b1;
            end else begin
              state <= ACCESS;
            end
`else
            state <= ACCESS;
`endif
          end
        end

        ACCESS: begin
          asm_q    <= asm_next;
          byte_idx <= byte_idx + 2'd1;
          if (last_byte) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= we_q ? 32'd0 : load_result;
          end
        end

        RESP: begin
          // Single-cycle pulse; ready comes back for the following cycle
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
`ifdef MISALIGN_TRAP_EN
          err_q     <= 1'b0;
`endif
        end

        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

  // RAM write port. Reset blocks the write, so a store interrupted by
  // reset keeps the bytes it already wrote and drops the rest.
  always_ff @(posedge clk) begin
    if (!reset && (state == ACCESS) && we_q) begin
      mem[cur_addr] <= wr_byte;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed self-checking bench for data_mem_responder. Each scenario task
// drives its own stimulus and compares against hand-computed values.
// Expectations for misaligned accesses follow the MISALIGN_TRAP_EN macro.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_whb;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests_run;
  int tests_failed;

  data_mem_responder #(.ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_whb    (req_whb),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one request and wait for its response. lat is the response cycle
  // relative to the accept cycle T (N+1 for a normal access, 1 for a trap),
  // or 0 if no response arrived within the budget.
  task automatic do_req(input logic we, input logic [1:0] whb, input logic sgn,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic rdy_t1, output logic valid_after,
                        output logic rdy_after);
    int wait_cnt;
    @(negedge clk);
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_whb    = whb;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    rdata = 32'd0;
    err = 1'b0;
    rdy_t1 = req_ready;
    for (int c = 1; c <= 20; c++) begin
      if (rsp_valid) begin
        lat = c;
        rdata = rsp_rdata;
        err = rsp_err;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    valid_after = rsp_valid;
    rdy_after = req_ready;
  endtask

  // Plain byte store used to set up known RAM contents
  task automatic store_byte(input logic [7:0] addr, input logic [7:0] val);
    int l;
    logic [31:0] d;
    logic e, r1, va, ra;
    do_req(1'b1, 2'b00, 1'b0, addr, {24'd0, val}, l, d, e, r1, va, ra);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_whb = 2'b00;
    req_signed = 1'b0;
    req_addr = 8'd0;
    req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 0", req_ready); end
    tests_run++;
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    tests_run++;
    if (rsp_rdata !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", rsp_rdata); end
    tests_run++;
    if (rsp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", rsp_err); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL ready_after_reset: got %b expected 1", req_ready); end
  endtask

  task automatic test_store_load_word();
    int lat;
    logic [31:0] d;
    logic e, r1, va, ra;
    do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, lat, d, e, r1, va, ra);
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("[TB] FAIL store_word_latency: got %0d expected 5", lat); end
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("[TB] FAIL store_word_rdata: got %h expected 00000000", d); end
    tests_run++;
    if (e !== 1'b0) begin tests_failed++; $display("[TB] FAIL store_word_err: got %b expected 0", e); end
    tests_run++;
    if (r1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL store_word_busy: ready got %b expected 0", r1); end
    tests_run++;
    if (va !== 1'b0) begin tests_failed++; $display("[TB] FAIL store_word_pulse_len: rsp_valid got %b expected 0", va); end
    tests_run++;
    if (ra !== 1'b1) begin tests_failed++; $display("[TB] FAIL store_word_ready_back: got %b expected 1", ra); end
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'd0, lat, d, e, r1, va, ra);
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("[TB] FAIL load_word_latency: got %0d expected 5", lat); end
    tests_run++;
    if (d !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL load_word_data: got %h expected DEADBEEF", d); end
  endtask

  task automatic test_extension();
    int lat;
    logic [31:0] d;
    logic e, r1, va, ra;
    do_req(1'b0, 2'b00, 1'b1, 8'h10, 32'd0, lat, d, e, r1, va, ra);
    tests_run++;
    if (d !== 32'hFFFFFFEF) begin tests_failed++; $display("[TB] FAIL byte_signed: got %h expected FFFFFFEF", d); end
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("[TB] FAIL byte_latency: got %0d expected 2", lat); end
    do_req(1'b0, 2'b00, 1'b0, 8'h10, 32'd0, lat, d, e, r1, va, ra);
    tests_run++;
    if (d !== 32'h000000EF) begin tests_failed++; $display("[TB] FAIL byte_unsigned: got %h expected 000000EF", d); end
    do_req(1'b0, 2'b01, 1'b1, 8'h12, 32'd0, lat, d, e, r1, va, ra);
    tests_run++;
    if (d !== 32'hFFFFDEAD) begin tests_failed++; $display("[TB] FAIL half_signed: got %h expected FFFFDEAD", d); end
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("[TB] FAIL half_latency: got %0d expected 3", lat); end
    do_req(1'b0, 2'b01, 1'b0, 8'h12, 32'd0, lat, d, e, r1, va, ra);
    tests_run++;
    if (d !== 32'h0000DEAD) begin tests_failed++; $display("[TB] FAIL half_unsigned: got %h expected 0000DEAD", d); end
  endtask

  task automatic test_half_store();
    int lat;
    logic [31:0] d;
    logic e, r1, va, ra;
    // whb=11 acts as a word store
    do_req(1'b1, 2'b11, 1'b0, 8'h20, 32'hCAFEF00D, lat, d, e, r1, va, ra);
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("[TB] FAIL whb11_latency: got %0d expected 5", lat); end
    do_req(1'b1, 2'b01, 1'b0, 8'h20, 32'h99991234, lat, d, e, r1, va, ra);
    do_req(1'b0, 2'b10, 1'b0, 8'h20, 32'd0, lat, d, e, r1, va, ra);
    tests_run++;
    if (d !== 32'hCAFE1234) begin tests_failed++; $display("[TB] FAIL half_store_merge: got %h expected CAFE1234", d); end
  endtask

  task automatic test_wrap();
    int lat;
    logic [31:0] d;
    logic e, r1, va, ra;
    logic [7:0] exp_bytes [4];
    logic [7:0] addrs [4];
    addrs[0] = 8'hFE; addrs[1] = 8'hFF; addrs[2] = 8'h00; addrs[3] = 8'h01;
    store_byte(8'hFE, 8'hA1);
    store_byte(8'hFF, 8'hA2);
    store_byte(8'h00, 8'hA3);
    store_byte(8'h01, 8'hA4);
    do_req(1'b1, 2'b10, 1'b0, 8'hFE, 32'h11223344, lat, d, e, r1, va, ra);
`ifdef MISALIGN_TRAP_EN
    tests_run++;
    if (e !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_trap_err: got %b expected 1", e); end
    tests_run++;
    if (lat !== 1) begin tests_failed++; $display("[TB] FAIL wrap_trap_latency: got %0d expected 1", lat); end
    exp_bytes[0] = 8'hA1; exp_bytes[1] = 8'hA2; exp_bytes[2] = 8'hA3; exp_bytes[3] = 8'hA4;
`else
    tests_run++;
    if (e !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_err: got %b expected 0", e); end
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("[TB] FAIL wrap_latency: got %0d expected 5", lat); end
    exp_bytes[0] = 8'h44; exp_bytes[1] = 8'h33; exp_bytes[2] = 8'h22; exp_bytes[3] = 8'h11;
`endif
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 2'b00, 1'b0, addrs[i], 32'd0, lat, d, e, r1, va, ra);
      tests_run++;
      if (d !== {24'd0, exp_bytes[i]}) begin
        tests_failed++;
        $display("[TB] FAIL wrap_byte_%0d: got %h expected %h", i, d, {24'd0, exp_bytes[i]});
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_rsp;
    for (int i = 0; i < 12; i++) store_byte(8'h40 + 8'(i), 8'h80 + 8'(i));
    n_rsp = 0;
    // Byte loads take 3 cycles, so with valid held high and the address
    // moving every cycle, accepts land on addresses 0x40, 0x43, 0x46
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_whb    = 2'b00;
      req_signed = 1'b0;
      req_addr   = 8'h40 + 8'(c);
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        tests_run++;
        if (c !== 3 * n_rsp + 1) begin tests_failed++; $display("[TB] FAIL b2b_timing_%0d: got cycle %0d expected %0d", n_rsp, c, 3 * n_rsp + 1); end
        tests_run++;
        if (rsp_rdata !== 32'h80 + 32'(3 * n_rsp)) begin
          tests_failed++;
          $display("[TB] FAIL b2b_data_%0d: got %h expected %h", n_rsp, rsp_rdata, 32'h80 + 32'(3 * n_rsp));
        end
        n_rsp++;
      end
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (n_rsp !== 3) begin tests_failed++; $display("[TB] FAIL b2b_count: got %0d expected 3", n_rsp); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int seen;
    logic [31:0] d;
    logic e, r1, va, ra;
    for (int i = 0; i < 4; i++) store_byte(8'h60 + 8'(i), 8'h55);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_whb    = 2'b10;
    req_signed = 1'b0;
    req_addr   = 8'h60;
    req_wdata  = 32'hA1B2C3D4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // Bytes 0 and 1 are written on the next two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_reset_ready: got %b expected 1", req_ready); end
    repeat (4) begin
      if (rsp_valid) seen++;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (seen !== 0) begin tests_failed++; $display("[TB] FAIL mid_reset_no_rsp: got %0d pulses expected 0", seen); end
    do_req(1'b0, 2'b10, 1'b0, 8'h60, 32'd0, lat, d, e, r1, va, ra);
    tests_run++;
    if (d !== 32'h5555C3D4) begin tests_failed++; $display("[TB] FAIL mid_reset_bytes: got %h expected 5555C3D4", d); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_store_load_word();
    test_extension();
    test_half_store();
    test_wrap();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
